// File: rtl/arb_pkg.sv
// Shared state, owner codes and sizing helpers for the memory port arbiter.
package arb_pkg;

  localparam int unsigned DEF_AW = 32;
  localparam int unsigned DEF_DW = 32;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP_I,
    RESP_D
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arb_age_cnt.sv
// Saturating up-counter with clear; sat_o is high while the count equals MAX.
module arb_age_cnt
  import arb_pkg::*;
#(
  parameter int unsigned MAX = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam int unsigned CW = cnt_width(MAX);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sat_q;

  // Clear wins over increment; increment stops at MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CW'(MAX))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
      sat_q <= (MAX == 0);
    end else begin
      cnt_q <= cnt_d;
      sat_q <= (cnt_d == CW'(MAX));
    end
  end

  assign sat_o = sat_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between I-cache and D-side, D priority with I aging.
// Optional MEM_TIMEOUT_EN: abandon a BUSY transaction after TIMEOUT cycles and flag err.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned DW       = DEF_DW,
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ready,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner,
  output logic          err
);

  state_t state_q;
  logic   idle, grant_i, grant_d, age_inc, age_sat, to_hit;

  assign idle    = (state_q == IDLE);
  assign grant_i = idle && i_req && (!d_req || age_sat);
  assign grant_d = idle && d_req && !grant_i;
  assign age_inc = grant_d && i_req;

  arb_age_cnt #(.MAX(MAX_WAIT)) u_age_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc_i (age_inc),
    .clr_i (grant_i),
    .sat_o (age_sat)
  );

`ifdef MEM_TIMEOUT_EN
  logic busy, to_sat;
  assign busy = (state_q == BUSY_I) || (state_q == BUSY_D);

  // Saturates on the TIMEOUT-th BUSY cycle; cleared whenever not BUSY.
  arb_age_cnt #(.MAX(TIMEOUT - 1)) u_to_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc_i (busy),
    .clr_i (!busy),
    .sat_o (to_sat)
  );
  assign to_hit = busy && to_sat;
`else
  // No timeout: BUSY waits for mem_ack indefinitely.
  assign to_hit = 1'b0 && (TIMEOUT != 0);
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      owner     <= OWN_NONE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ready   <= 1'b0;
      i_rdata   <= '0;
      d_ready   <= 1'b0;
      d_rdata   <= '0;
      err       <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      err     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_i) begin
            state_q   <= BUSY_I;
            owner     <= OWN_I;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
          end else if (grant_d) begin
            state_q   <= BUSY_D;
            owner     <= OWN_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end
        end
        BUSY_I: begin
          // An ack in the timeout cycle still counts as a normal completion.
          if (mem_ack) begin
            state_q <= RESP_I;
            mem_req <= 1'b0;
            i_ready <= 1'b1;
            i_rdata <= mem_rdata;
          end else if (to_hit) begin
            state_q <= RESP_I;
            mem_req <= 1'b0;
            i_ready <= 1'b1;
            i_rdata <= '0;
            err     <= 1'b1;
          end
        end
        BUSY_D: begin
          if (mem_ack) begin
            state_q <= RESP_D;
            mem_req <= 1'b0;
            d_ready <= 1'b1;
            d_rdata <= mem_rdata;
          end else if (to_hit) begin
            state_q <= RESP_D;
            mem_req <= 1'b0;
            d_ready <= 1'b1;
            d_rdata <= '0;
            err     <= 1'b1;
          end
        end
        RESP_I, RESP_D: begin
          state_q <= IDLE;
          owner   <= OWN_NONE;
        end
        default: begin
          state_q <= IDLE;
          owner   <= OWN_NONE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level reference model plus directed scenarios.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int MAX_WAIT = 8;
  localparam int TIMEOUT  = 64;
`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_req, i_ready, d_req, d_we, d_ready;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic [DW-1:0] i_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
  logic          mem_req, mem_we, mem_ack, err;
  logic [1:0]    owner;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .owner(owner), .err(err)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: which side holds the port, whether it is in its response cycle,
  // how many times I has lost, and how long the memory has been waited on.
  int            m_side;
  bit            m_resp;
  int            m_age;
  int            m_busy_n;
  bit            m_started = 1'b0;
  bit            m_pick_i;
  logic          exp_mem_req, exp_mem_we, exp_i_ready, exp_d_ready, exp_err;
  logic [AW-1:0] exp_mem_addr;
  logic [DW-1:0] exp_mem_wdata, exp_i_rdata, exp_d_rdata;

  task automatic m_complete(input logic [DW-1:0] data, input logic to);
    if (m_side == 1) begin
      exp_i_ready = 1'b1;
      exp_i_rdata = data;
    end else begin
      exp_d_ready = 1'b1;
      exp_d_rdata = data;
    end
    exp_err     = to;
    exp_mem_req = 1'b0;
    m_resp      = 1'b1;
  endtask

  always @(posedge clk) begin
    exp_i_ready = 1'b0;
    exp_d_ready = 1'b0;
    exp_err     = 1'b0;
    if (!rstn) begin
      m_started     = 1'b1;
      m_side        = 0;
      m_resp        = 1'b0;
      m_age         = 0;
      m_busy_n      = 0;
      exp_mem_req   = 1'b0;
      exp_mem_we    = 1'b0;
      exp_mem_addr  = '0;
      exp_mem_wdata = '0;
      exp_i_rdata   = '0;
      exp_d_rdata   = '0;
    end else if (m_side == 0) begin
      if (i_req || d_req) begin
        m_pick_i    = i_req && (!d_req || m_age == MAX_WAIT);
        m_busy_n    = 0;
        exp_mem_req = 1'b1;
        if (m_pick_i) begin
          m_side        = 1;
          m_age         = 0;
          exp_mem_we    = 1'b0;
          exp_mem_addr  = i_addr;
          exp_mem_wdata = '0;
        end else begin
          m_side = 2;
          if (i_req && m_age < MAX_WAIT) m_age++;
          exp_mem_we    = d_we;
          exp_mem_addr  = d_addr;
          exp_mem_wdata = d_wdata;
        end
      end
    end else if (m_resp) begin
      m_side = 0;
      m_resp = 1'b0;
    end else begin
      m_busy_n++;
      if (mem_ack) m_complete(mem_rdata, 1'b0);
      else if (TO_EN && m_busy_n >= TIMEOUT) m_complete('0, 1'b1);
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("owner",   64'(owner),   64'(m_side));
      chk("mem_req", 64'(mem_req), 64'(exp_mem_req));
      chk("i_ready", 64'(i_ready), 64'(exp_i_ready));
      chk("d_ready", 64'(d_ready), 64'(exp_d_ready));
      chk("err",     64'(err),     64'(exp_err));
      chk("i_rdata", 64'(i_rdata), 64'(exp_i_rdata));
      chk("d_rdata", 64'(d_rdata), 64'(exp_d_rdata));
      if (exp_mem_req) begin
        chk("mem_we",    64'(mem_we),    64'(exp_mem_we));
        chk("mem_addr",  64'(mem_addr),  64'(exp_mem_addr));
        chk("mem_wdata", 64'(mem_wdata), 64'(exp_mem_wdata));
      end
    end
  end

  int         grants[$];
  logic [1:0] prev_owner;
  int         n;
  bit         err_seen;

  initial begin
    rstn = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    chk("rst_owner",   64'(owner),   64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_i_ready", 64'(i_ready), 64'd0);
    chk("rst_err",     64'(err),     64'd0);

    // Single I request, ack on the third BUSY cycle.
    i_req = 1'b1; i_addr = 32'h40;
    tick();
    chk("t1_c1_mem_req", 64'(mem_req),  64'd1);
    chk("t1_c1_addr",    64'(mem_addr), 64'h40);
    chk("t1_c1_we",      64'(mem_we),   64'd0);
    chk("t1_c1_owner",   64'(owner),    64'd1);
    tick();
    chk("t1_c2_mem_req", 64'(mem_req), 64'd1);
    tick();
    chk("t1_c3_mem_req", 64'(mem_req), 64'd1);
    chk("t1_c3_i_ready", 64'(i_ready), 64'd0);
    mem_ack = 1'b1; mem_rdata = 32'h13;
    tick();
    mem_ack = 1'b0;
    chk("t1_c4_i_ready", 64'(i_ready), 64'd1);
    chk("t1_c4_i_rdata", 64'(i_rdata), 64'h13);
    chk("t1_c4_owner",   64'(owner),   64'd1);
    chk("t1_c4_mem_req", 64'(mem_req), 64'd0);
    i_req = 1'b0;
    tick();
    chk("t1_c5_i_ready", 64'(i_ready), 64'd0);
    chk("t1_c5_owner",   64'(owner),   64'd0);
    chk("t1_c5_i_rdata", 64'(i_rdata), 64'h13);

    // Simultaneous requests: D first, then I.
    i_req = 1'b1; i_addr = 32'h80;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    tick();
    chk("t2_owner_d", 64'(owner),     64'd2);
    chk("t2_we",      64'(mem_we),    64'd1);
    chk("t2_wdata",   64'(mem_wdata), 64'hDEADBEEF);
    chk("t2_addr",    64'(mem_addr),  64'h100);
    mem_ack = 1'b1; mem_rdata = 32'h55;
    tick();
    mem_ack = 1'b0;
    chk("t2_d_ready", 64'(d_ready), 64'd1);
    chk("t2_d_rdata", 64'(d_rdata), 64'h55);
    chk("t2_i_ready", 64'(i_ready), 64'd0);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    chk("t2_idle", 64'(owner), 64'd0);
    tick();
    chk("t2_owner_i", 64'(owner),    64'd1);
    chk("t2_i_addr",  64'(mem_addr), 64'h80);
    chk("t2_i_we",    64'(mem_we),   64'd0);
    mem_ack = 1'b1; mem_rdata = 32'h77;
    tick();
    mem_ack = 1'b0;
    chk("t2_i_ready2", 64'(i_ready), 64'd1);
    chk("t2_i_rdata",  64'(i_rdata), 64'h77);
    i_req = 1'b0;
    tick();

    // Starvation: both requests held, memory always acks.
    i_req = 1'b1; i_addr = 32'hC0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    mem_ack = 1'b1;
    prev_owner = owner;
    for (int c = 0; c < 60; c++) begin
      mem_rdata = $urandom;
      tick();
      if (prev_owner == 2'd0 && owner != 2'd0) grants.push_back(int'(owner));
      prev_owner = owner;
    end
    chk("t3_enough_grants", 64'(grants.size() >= 18), 64'd1);
    if (grants.size() >= 18) begin
      for (int k = 0; k < 18; k++) begin
        chk($sformatf("t3_grant%0d", k), 64'(grants[k]), (k == 8 || k == 17) ? 64'd1 : 64'd2);
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (3) tick();
    mem_ack = 1'b0;
    tick();

    // Reset while BUSY_D.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    tick();
    chk("t4_busy_owner", 64'(owner),   64'd2);
    chk("t4_busy_req",   64'(mem_req), 64'd1);
    tick();
    rstn = 1'b0; d_req = 1'b0;
    tick();
    chk("t4_rst_mem_req", 64'(mem_req), 64'd0);
    chk("t4_rst_owner",   64'(owner),   64'd0);
    chk("t4_rst_d_ready", 64'(d_ready), 64'd0);
    chk("t4_rst_d_rdata", 64'(d_rdata), 64'd0);
    rstn = 1'b1;
    tick();
    chk("t4_no_ready", 64'(d_ready), 64'd0);
    d_req = 1'b1; d_addr = 32'h204;
    tick();
    chk("t4_fresh_owner", 64'(owner),    64'd2);
    chk("t4_fresh_addr",  64'(mem_addr), 64'h204);
    mem_ack = 1'b1; mem_rdata = 32'hA5A5;
    tick();
    mem_ack = 1'b0;
    chk("t4_fresh_ready", 64'(d_ready), 64'd1);
    chk("t4_fresh_rdata", 64'(d_rdata), 64'hA5A5);
    d_req = 1'b0;
    tick();

    // Spurious ack in IDLE, then I request withdrawn mid-transaction.
    mem_ack = 1'b1; mem_rdata = 32'hBAD;
    tick();
    chk("t5_spur_i", 64'(i_ready), 64'd0);
    chk("t5_spur_d", 64'(d_ready), 64'd0);
    chk("t5_spur_owner", 64'(owner), 64'd0);
    tick();
    chk("t5_spur_owner2", 64'(owner), 64'd0);
    mem_ack = 1'b0;
    i_req = 1'b1; i_addr = 32'h44;
    tick();
    tick();
    i_req = 1'b0;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h99;
    tick();
    mem_ack = 1'b0;
    chk("t5_wd_ready", 64'(i_ready), 64'd1);
    chk("t5_wd_rdata", 64'(i_rdata), 64'h99);
    tick();

    // Memory never acks.
    i_req = 1'b1; i_addr = 32'h48;
    tick();
    n = 0; err_seen = 1'b0;
    while (mem_req === 1'b1 && n < 200) begin
      n++;
      if (err) err_seen = 1'b1;
      tick();
    end
`ifdef MEM_TIMEOUT_EN
    chk("t6_busy_cycles", 64'(n), 64'd64);
    chk("t6_i_ready", 64'(i_ready), 64'd1);
    chk("t6_err",     64'(err),     64'd1);
    chk("t6_i_rdata", 64'(i_rdata), 64'd0);
    i_req = 1'b0;
    tick();
    chk("t6_err_gone", 64'(err), 64'd0);
`else
    chk("t6_busy_cycles", 64'(n),        64'd200);
    chk("t6_still_req",   64'(mem_req),  64'd1);
    chk("t6_no_err",      64'(err_seen), 64'd0);
    mem_ack = 1'b1; mem_rdata = 32'h1234;
    tick();
    mem_ack = 1'b0; i_req = 1'b0;
    chk("t6_late_ready", 64'(i_ready), 64'd1);
    chk("t6_late_err",   64'(err),     64'd0);
    tick();
`endif

    // Randomized traffic, checked every cycle by the model.
    for (int c = 0; c < 4000; c++) begin
      if (i_ready) i_req = 1'b0;
      else if (!i_req) begin
        if ($urandom_range(0, 2) == 0) begin i_req = 1'b1; i_addr = $urandom; end
      end else if ($urandom_range(0, 99) == 0) i_req = 1'b0;
      if (d_ready) d_req = 1'b0;
      else if (!d_req) begin
        if ($urandom_range(0, 1) == 0) begin
          d_req = 1'b1; d_addr = $urandom; d_wdata = $urandom;
          d_we = 1'($urandom_range(0, 1));
        end
      end else if ($urandom_range(0, 99) == 0) d_req = 1'b0;
      mem_ack   = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      rstn      = ($urandom_range(0, 299) != 0);
      tick();
    end

    rstn = 1'b1; i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b1;
    repeat (4) tick();
    mem_ack = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
